// File: rtl/mult_div_pkg.sv
// Shared definitions for the shift-add multiplier and shift-subtract divider controls.
package mult_div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_SHIFT = 3'd2,
        ST_SUB   = 3'd3,
        ST_DONE  = 3'd4
    } md_state_e;

    localparam int MD_WIDTH      = 32;
    localparam int MD_CNT_W      = 6;
    localparam int MD_ITER_LIMIT = MD_WIDTH;

endpackage

// File: rtl/div_control_fsm.sv
// Divider sequencer: state register, iteration counter and strobes to the datapath.
//   state | meaning
//   IDLE  | waiting for start; operands loaded on the accepting edge
//   CHECK | divisor==0 test; short-circuits to DONE
//   SHIFT | {A,Q} shifted left by one
//   SUB   | conditional A-D, quotient bit set; counts iterations
//   DONE  | one-cycle valid
module div_control_fsm
    import mult_div_pkg::*;
#(
    parameter int ITERS = MD_ITER_LIMIT,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic a_ge_d,
    input  logic d_zero,
    output logic busy,
    output logic valid,
    output logic load,
    output logic shift,
    output logic sub_en,
    output logic done,
    output logic dbz
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_iter;

    assign last_iter = (cnt_q == CNT_W'(ITERS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b1;
        valid   = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        sub_en  = 1'b0;
        done    = 1'b0;
        dbz     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (d_zero) begin
                    dbz     = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift   = 1'b1;
                state_d = ST_SUB;
            end
            ST_SUB: begin
                // sub_en alone tells the datapath to subtract and set Q[0]
                sub_en  = a_ge_d;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    done    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                valid   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/shift_sub_divider.sv
// Restoring shift-and-subtract divider: A/Q/D datapath plus result registers.
module shift_sub_divider
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    logic [WIDTH:0]   a_q, a_d, a_diff;
    logic [WIDTH-1:0] q_q, q_d, d_q, d_d;
    logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             a_ge_d, load, shift, sub_en, done, dbz;

    // A carries an extra bit so the compare and subtract never overflow
    assign a_ge_d = (a_q >= {1'b0, d_q});
    assign a_diff = a_q - {1'b0, d_q};

    div_control_fsm #(.ITERS(WIDTH), .CNT_W(CNT_W)) u_ctrl (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a_ge_d (a_ge_d),
        .d_zero (d_q == '0),
        .busy   (busy),
        .valid  (valid),
        .load   (load),
        .shift  (shift),
        .sub_en (sub_en),
        .done   (done),
        .dbz    (dbz)
    );

    always_comb begin
        a_d    = a_q;
        q_d    = q_q;
        d_d    = d_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        if (load) begin
            a_d   = '0;
            q_d   = dividend;
            d_d   = divisor;
            dbz_d = 1'b0;
        end
        if (shift) begin
            a_d = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
            q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        // Q[0] is already 0 from the shift, so only the subtracting case changes it
        if (sub_en) begin
            a_d = a_diff;
            q_d = {q_q[WIDTH-1:1], 1'b1};
        end
        if (done) begin
            quot_d = q_d;
            rem_d  = a_d[WIDTH-1:0];
        end
        if (dbz) begin
            quot_d = '1;
            rem_d  = q_q;
            dbz_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            q_q    <= '0;
            d_q    <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            q_q    <= q_d;
            d_q    <= d_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dbz_q  <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed bench for shift_sub_divider: vector table plus handshake corner sequences.
module tb_shift_sub_divider;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, valid, div_by_zero;
    logic [31:0] quotient, remainder;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_sub_divider dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .valid       (valid),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          cyc;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive operands at a negedge, let the next rising edge accept, then scramble operands.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0003;
    endtask

    // Called just after the accepting edge; samples each cycle at the negedge.
    task automatic wait_result(input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                               input int ecyc, input int inj_cyc, input bit chain, input string tag);
        int  cyc;
        bit  got;
        bit  busy_ok;
        got     = 1'b0;
        busy_ok = 1'b1;
        for (cyc = 1; cyc <= 150; cyc++) begin
            @(negedge clk);
            if (cyc == inj_cyc) begin
                dividend = 32'd50;
                divisor  = 32'd5;
                start    = 1'b1;
            end else if (cyc == inj_cyc + 1) begin
                start = 1'b0;
            end
            if (!busy) busy_ok = 1'b0;
            if (valid) begin
                got = 1'b1;
                break;
            end
        end
        check(got && cyc == ecyc, {tag, " valid_cycle"}, got ? cyc : -1, ecyc);
        check(busy_ok, {tag, " busy_while_running"}, busy_ok, 1);
        check(quotient == eq, {tag, " quotient"}, quotient, eq);
        check(remainder == er, {tag, " remainder"}, remainder, er);
        check(div_by_zero == edbz, {tag, " div_by_zero"}, div_by_zero, edbz);
        if (!chain) begin
            @(negedge clk);
            check(!valid && !busy, {tag, " valid_one_cycle"}, {valid, busy}, 0);
            check(quotient == eq, {tag, " quotient_held"}, quotient, eq);
        end
    endtask

    initial begin
        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,    1'b0, 66};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,    1'b0, 66};
        vecs[2] = '{32'd5,          32'd10,         32'd0,          32'd5,    1'b0, 66};
        vecs[3] = '{32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234, 1'b1, 2};
        vecs[4] = '{32'd9,          32'd3,          32'd3,          32'd0,    1'b0, 66};
        vecs[5] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,    1'b0, 66};
        vecs[6] = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,    1'b1, 2};
        vecs[7] = '{32'd1000000007, 32'd1000,       32'd1000000,    32'd7,    1'b0, 66};
        vecs[8] = '{32'd0,          32'd5,          32'd0,          32'd0,    1'b0, 66};

        #1;
        check(!busy && !valid, "reset busy_valid", {busy, valid}, 0);
        check(quotient == 0 && remainder == 0, "reset results", quotient | remainder, 0);
        check(!div_by_zero, "reset div_by_zero", div_by_zero, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            start_op(vecs[i].dvd, vecs[i].dvs);
            wait_result(vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].cyc, -10, 1'b0,
                        $sformatf("vec%0d", i));
        end

        // start with new operands mid-operation must be ignored
        start_op(32'd100, 32'd7);
        wait_result(32'd14, 32'd2, 1'b0, 66, 30, 1'b0, "ignore_start");

        // leave a nonzero result visible, then abort a run with reset at cycle 20
        start_op(32'd9, 32'd3);
        wait_result(32'd3, 32'd0, 1'b0, 66, -10, 1'b0, "pre_abort");
        start_op(32'd100, 32'd7);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1;
        check(!busy && !valid, "abort busy_valid", {busy, valid}, 0);
        check(quotient == 0 && remainder == 0, "abort results", quotient | remainder, 0);
        @(negedge clk);
        check(!busy && !valid, "abort held", {busy, valid}, 0);
        reset = 1'b0;
        start_op(32'd81, 32'd9);
        wait_result(32'd9, 32'd0, 1'b0, 66, -10, 1'b0, "after_abort");

        // back-to-back: start held through DONE, accepted in the first IDLE cycle
        start_op(32'd7, 32'd2);
        wait_result(32'd3, 32'd1, 1'b0, 66, -10, 1'b1, "b2b_first");
        dividend = 32'h8000_0000;
        divisor  = 32'h0000_0010;
        start    = 1'b1;
        @(negedge clk);
        check(!busy && !valid, "b2b idle_gap", {busy, valid}, 0);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 32'h1234_5678;
        wait_result(32'h0800_0000, 32'd0, 1'b0, 66, -10, 1'b0, "b2b_second");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
